// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: request/response front end for a synchronous RAM port.
// Credit-based flow control keeps the response FIFO from ever overflowing.
module ram_port_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_LATENCY = 2,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  ram_clk_en,
    output logic                  ram_wr_en,
    output logic                  ram_rd_clk_en,
    output logic                  ram_rd_reg_rst,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [1:0]            r_rst_pipe;
    logic [RD_LATENCY-1:0] r_rd_pipe;
    logic [DATA_WIDTH-1:0] r_fifo [RSP_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic [CNT_W-1:0]      w_inflight;
    logic [CNT_W-1:0]      w_outstanding;
    logic                  w_hold;
    logic                  w_issue;
    logic                  w_rd_issue;
    logic                  w_push;
    logic                  w_pop;

    // Recovery: hold the RAM output register in reset for one extra clock
    assign w_hold         = r_rst_pipe[1];
    assign ram_rd_reg_rst = w_hold;
    assign ram_rd_clk_en  = ~w_hold;

    // Credit depends only on registered state, so a pop frees credit next cycle
    assign w_outstanding = w_inflight + r_count;
    assign req_ready     = ~w_hold && (w_outstanding < DEPTH_C);

    assign w_issue    = req_valid & req_ready;
    assign w_rd_issue = w_issue & ~req_wr;
    assign w_push     = r_rd_pipe[RD_LATENCY-1];
    assign w_pop      = rsp_valid & rsp_ready;

    assign ram_clk_en  = w_issue;
    assign ram_wr_en   = w_issue & req_wr;
    assign ram_addr    = req_addr;
    assign ram_wr_data = req_wdata;

    assign rsp_valid = (r_count != '0);
    assign rsp_data  = r_fifo[r_rd_ptr];

    // Count reads still travelling through the RAM pipeline
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_rd_pipe[i]);
        end
    end

    // Two-stage release so recovery lasts one full clock after reset
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_rst_pipe <= 2'b11;
        end else begin
            r_rst_pipe <= {r_rst_pipe[0], 1'b0};
        end
    end

    // Read-valid shift register aligned with the RAM read latency
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe[0] <= w_rd_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap at the power-of-two depth
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Response storage; visibility is gated by r_count so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= ram_rd_data;
        end
    end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: two instances (read latency 2 and 1) on shared stimulus,
// each with its own RAM model and a queue-based reference model.
`timescale 1ns/1ps
module tb_ram_port_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] d;
        int         due;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid;
    logic       req_wr;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_ready;

    logic       o_req_ready [2];
    logic       o_clk_en    [2];
    logic       o_wr_en     [2];
    logic       o_rd_clk_en [2];
    logic       o_reg_rst   [2];
    logic       o_rsp_valid [2];
    logic [3:0] o_addr      [2];
    logic [7:0] o_wdata     [2];
    logic [7:0] o_rsp_data  [2];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(int a);
        return 8'(a * 17 + 3);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int LAT = (g == 0) ? 2 : 1;

        logic [7:0]  rd_data;
        logic [7:0]  mem [16];
        logic [15:0] wrt = '0;
        logic [7:0]  r1 = '0;
        logic [7:0]  r2 = '0;

        rsp_t        q[$];
        logic [7:0]  rm [16];
        logic [15:0] rwrt = '0;
        int          recov = 2;
        int          cyc = 0;

        ram_port_ctrl #(
            .DATA_WIDTH(DW),
            .ADDR_WIDTH(AW),
            .RD_LATENCY(LAT),
            .RSP_DEPTH(DEPTH)
        ) dut (
            .clk(clk),
            .async_rst_n(rst_n),
            .req_valid(req_valid),
            .req_ready(o_req_ready[g]),
            .req_wr(req_wr),
            .req_addr(req_addr),
            .req_wdata(req_wdata),
            .ram_clk_en(o_clk_en[g]),
            .ram_wr_en(o_wr_en[g]),
            .ram_rd_clk_en(o_rd_clk_en[g]),
            .ram_rd_reg_rst(o_reg_rst[g]),
            .ram_addr(o_addr[g]),
            .ram_wr_data(o_wdata[g]),
            .ram_rd_data(rd_data),
            .rsp_valid(o_rsp_valid[g]),
            .rsp_ready(rsp_ready),
            .rsp_data(o_rsp_data[g])
        );

        // Synchronous RAM: array read register r1, optional output register r2
        always @(posedge clk) begin
            if (o_clk_en[g]) begin
                if (o_wr_en[g]) begin
                    mem[o_addr[g]] <= o_wdata[g];
                    wrt[o_addr[g]] <= 1'b1;
                end else begin
                    r1 <= wrt[o_addr[g]] ? mem[o_addr[g]] : init_val(int'(o_addr[g]));
                end
            end
            if (o_reg_rst[g]) r2 <= '0;
            else if (o_rd_clk_en[g]) r2 <= r1;
        end
        assign rd_data = (LAT == 2) ? r2 : r1;

        // Reference model: each unpopped read is one credit; it is visible
        // as a response from issue cycle + LAT + 1 onwards
        initial forever begin
            bit   rdy;
            bit   vld;
            rsp_t e;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                recov = 2;
            end else begin
                rdy = (recov == 0) && (q.size() < DEPTH);
                vld = (q.size() > 0) && (q[0].due <= cyc);
                if (vld && rsp_ready) void'(q.pop_front());
                if (req_valid && rdy) begin
                    if (req_wr) begin
                        rm[req_addr]   = req_wdata;
                        rwrt[req_addr] = 1'b1;
                    end else begin
                        e.d   = rwrt[req_addr] ? rm[req_addr] : init_val(int'(req_addr));
                        e.due = cyc + LAT + 1;
                        q.push_back(e);
                    end
                end
                if (recov > 0) recov--;
                cyc++;
            end
        end

        initial forever begin
            bit    rdy;
            bit    vld;
            bit    iss;
            string p;
            @(negedge clk);
            if (chk_en) begin
                p   = (LAT == 2) ? "L2" : "L1";
                rdy = (recov == 0) && (q.size() < DEPTH);
                vld = (q.size() > 0) && (q[0].due <= cyc);
                iss = req_valid && rdy;
                chk({p, ".req_ready"}, 32'(o_req_ready[g]), 32'(rdy));
                chk({p, ".rsp_valid"}, 32'(o_rsp_valid[g]), 32'(vld));
                if (vld) chk({p, ".rsp_data"}, 32'(o_rsp_data[g]), 32'(q[0].d));
                chk({p, ".ram_clk_en"}, 32'(o_clk_en[g]), 32'(iss));
                chk({p, ".ram_wr_en"}, 32'(o_wr_en[g]), 32'(iss && req_wr));
                if (iss) begin
                    chk({p, ".ram_addr"}, 32'(o_addr[g]), 32'(req_addr));
                    chk({p, ".ram_wr_data"}, 32'(o_wdata[g]), 32'(req_wdata));
                end
                chk({p, ".rd_clk_en"}, 32'(o_rd_clk_en[g]), 32'(recov == 0));
                chk({p, ".rd_reg_rst"}, 32'(o_reg_rst[g]), 32'(recov != 0));
            end
        end
    end

    task automatic drive(bit v, bit w, int a, int d, bit rr);
        @(posedge clk);
        #1;
        req_valid = v;
        req_wr    = w;
        req_addr  = 4'(a);
        req_wdata = 8'(d);
        rsp_ready = rr;
    endtask

    task automatic chk_reset_state(string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, ".ready"}, 32'(o_req_ready[i]), 0);
            chk({tag, ".valid"}, 32'(o_rsp_valid[i]), 0);
            chk({tag, ".clk_en"}, 32'(o_clk_en[i]), 0);
            chk({tag, ".rd_clk_en"}, 32'(o_rd_clk_en[i]), 0);
            chk({tag, ".reg_rst"}, 32'(o_reg_rst[i]), 1);
        end
    endtask

    task automatic release_and_check(string tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, ".pre_edge_reg_rst"}, 32'(o_reg_rst[0]), 1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk({tag, ".clk1_reg_rst"}, 32'(o_reg_rst[i]), 1);
            chk({tag, ".clk1_ready"}, 32'(o_req_ready[i]), 0);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk({tag, ".clk2_reg_rst"}, 32'(o_reg_rst[i]), 0);
            chk({tag, ".clk2_ready"}, 32'(o_req_ready[i]), 1);
            chk({tag, ".clk2_rd_clk_en"}, 32'(o_rd_clk_en[i]), 1);
        end
    endtask

    initial begin
        int         n_iss;
        logic [7:0] exp_d [3];

        req_valid = 0;
        req_wr    = 0;
        req_addr  = 0;
        req_wdata = 0;
        rsp_ready = 0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk_reset_state("rst");
        release_and_check("rel");

        // Write 0xA5 to addr 3, read it back next cycle
        drive(1, 1, 3, 8'hA5, 0);
        @(negedge clk);
        chk("wr.clk_en", 32'(o_clk_en[0]), 1);
        chk("wr.wr_en", 32'(o_wr_en[0]), 1);
        drive(1, 0, 3, 0, 0);
        @(negedge clk);
        chk("rd.clk_en", 32'(o_clk_en[0]), 1);
        chk("rd.wr_en", 32'(o_wr_en[0]), 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wrrd.L2_t1", 32'(o_rsp_valid[0]), 0);
        chk("wrrd.L1_t1", 32'(o_rsp_valid[1]), 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wrrd.L2_t2", 32'(o_rsp_valid[0]), 0);
        chk("wrrd.L1_t2", 32'(o_rsp_valid[1]), 1);
        chk("wrrd.L1_data", 32'(o_rsp_data[1]), 32'hA5);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wrrd.L2_t3", 32'(o_rsp_valid[0]), 1);
        chk("wrrd.L2_data", 32'(o_rsp_data[0]), 32'hA5);
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wrrd.drained", 32'(o_rsp_valid[0]), 0);

        // Fill the credit window with rsp_ready held low
        n_iss = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, k, 0, 0);
            @(negedge clk);
            if (o_clk_en[0]) n_iss++;
        end
        chk("full.issued", 32'(n_iss), 4);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("full.ready", 32'(o_req_ready[i]), 0);
                chk("full.valid", 32'(o_rsp_valid[i]), 1);
                chk("full.head", 32'(o_rsp_data[i]), 32'h03);
            end
        end

        // One pop: credit returns the following cycle
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("pop.data", 32'(o_rsp_data[0]), 32'h03);
        chk("pop.ready_same", 32'(o_req_ready[0]), 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pop.ready_next", 32'(o_req_ready[0]), 1);
        chk("pop.next_head", 32'(o_rsp_data[0]), 32'h14);
        exp_d[0] = 8'h14;
        exp_d[1] = 8'h25;
        exp_d[2] = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1);
            @(negedge clk);
            chk("drain.L2", 32'(o_rsp_data[0]), 32'(exp_d[k]));
            chk("drain.L1", 32'(o_rsp_data[1]), 32'(exp_d[k]));
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("drain.empty", 32'(o_rsp_valid[1]), 0);

        // Eight back-to-back reads with the consumer always ready
        for (int j = 0; j < 12; j++) begin
            drive(j < 8, 0, 8 + j, 0, 1);
            @(negedge clk);
            if (j < 8) chk("b2b.issue", 32'(o_clk_en[1]), 1);
            chk("b2b.L1_valid", 32'(o_rsp_valid[1]), 32'(j >= 2 && j < 10));
            if (j >= 2 && j < 10)
                chk("b2b.L1_data", 32'(o_rsp_data[1]), 32'(init_val(8 + j - 2)));
            chk("b2b.L2_valid", 32'(o_rsp_valid[0]), 32'(j >= 3 && j < 11));
            if (j >= 3 && j < 11)
                chk("b2b.L2_data", 32'(o_rsp_data[0]), 32'(init_val(8 + j - 3)));
        end

        // Reset while reads are in flight and responses are queued
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, k, 0, 0);
            @(negedge clk);
        end
        chk("mid.L1_valid_pre", 32'(o_rsp_valid[1]), 1);
        @(posedge clk);
        #1;
        req_valid = 0;
        rst_n     = 1'b0;
        #1;
        chk("mid.L2_valid_now", 32'(o_rsp_valid[0]), 0);
        chk("mid.L1_valid_now", 32'(o_rsp_valid[1]), 0);
        @(negedge clk);
        chk_reset_state("mid");
        release_and_check("mid_rel");
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 0, 1);
            @(negedge clk);
            chk("mid.no_rsp_L2", 32'(o_rsp_valid[0]), 0);
            chk("mid.no_rsp_L1", 32'(o_rsp_valid[1]), 0);
        end

        // Random traffic against the reference models
        for (int n = 0; n < 10000; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                  $urandom_range(0, 2) != 0);
        end
        for (int n = 0; n < 10; n++) begin
            drive(0, 0, 0, 0, 1);
        end
        @(negedge clk);
        chk("final.L2_empty", 32'(o_rsp_valid[0]), 0);
        chk("final.L1_empty", 32'(o_rsp_valid[1]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_port_ctrl.md
RAM_PORT_CTRL -- requirements
Module: ram_port_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the request write-data, RAM data and response data width.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the request and RAM address width.
REQ-003 Parameter RD_LATENCY, default 2, SHALL be the RAM read latency in clocks; only 1 or 2 are legal.
REQ-004 Parameter RSP_DEPTH, default 4, SHALL be the response FIFO depth; it SHALL be a power of two and at least 2.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all logic SHALL be on its rising edge.
REQ-006 Port async_rst_n, input, 1 bit, SHALL be the reset, asynchronous and active-low.
REQ-007 Port req_valid, input, 1 bit, SHALL indicate that a request is offered.
REQ-008 Port req_ready, output, 1 bit, SHALL indicate that a request can be accepted.
REQ-009 Port req_wr, input, 1 bit, SHALL select write (1) or read (0).
REQ-010 Port req_addr, input, ADDR_WIDTH bits, SHALL be the request address.
REQ-011 Port req_wdata, input, DATA_WIDTH bits, SHALL be the request write data.
REQ-012 Ports ram_clk_en, ram_wr_en, ram_rd_clk_en and ram_rd_reg_rst SHALL each be outputs, 1 bit, driving the RAM port controls of the same meaning.
REQ-013 Ports ram_addr (output, ADDR_WIDTH) and ram_wr_data (output, DATA_WIDTH) SHALL drive the RAM port address and write data.
REQ-014 Port ram_rd_data, input, DATA_WIDTH bits, SHALL be the RAM port read data.
REQ-015 Port rsp_valid, output, 1 bit, SHALL indicate that rsp_data holds a read response.
REQ-016 Port rsp_ready, input, 1 bit, SHALL indicate that the consumer accepts the response.
REQ-017 Port rsp_data, output, DATA_WIDTH bits, SHALL be the read response data.

Function
REQ-018 A request SHALL be accepted ("issued") in any cycle where req_valid and req_ready are both 1.
REQ-019 On issue, ram_clk_en SHALL be 1, ram_wr_en SHALL equal req_wr, and ram_addr/ram_wr_data SHALL equal req_addr/req_wdata; all are combinational that cycle.
REQ-020 With no issue, ram_clk_en and ram_wr_en SHALL be 0.
REQ-021 ram_rd_clk_en SHALL be constant 1 outside reset recovery.
REQ-022 A read issued in cycle t SHALL sample ram_rd_data at the end of cycle t+RD_LATENCY, tracked by a RD_LATENCY-deep valid shift register.
REQ-023 The sampled read data SHALL be pushed into the response FIFO.
REQ-024 Response latency SHALL therefore be a minimum of RD_LATENCY+1 cycles from issue to rsp_valid.
REQ-025 Writes SHALL generate no response.
REQ-026 Responses SHALL be returned in issue order.
REQ-027 rsp_valid SHALL equal FIFO non-empty, and rsp_data SHALL be the FIFO head; a pop SHALL occur when rsp_valid and rsp_ready are both 1.
REQ-028 rsp_data SHALL be held stable while rsp_valid is 1 and rsp_ready is 0.
REQ-029 Credit rule: outstanding = in-flight reads + FIFO count, and req_ready SHALL be 1 iff outstanding < RSP_DEPTH.
REQ-030 req_ready SHALL be registered-state only, with no combinational path from req_valid, req_wr or rsp_ready.
REQ-031 The FIFO SHALL never overflow; a push to a full FIFO is unreachable by REQ-029.
REQ-032 A pop SHALL not be credited in the same cycle; the credit SHALL return the next cycle.
REQ-033 Simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-034 FIFO pointers SHALL wrap modulo RSP_DEPTH.
REQ-035 Back-to-back issues, one per cycle, SHALL be sustained while credit remains.
REQ-036 Write and read to the same address in adjacent cycles SHALL be passed through unmodified; ordering semantics are those of the RAM.

Reset
REQ-037 While async_rst_n is 0: req_ready=0, rsp_valid=0, ram_clk_en=0, ram_wr_en=0, ram_rd_clk_en=0, ram_rd_reg_rst=1, FIFO empty, shift register cleared.
REQ-038 For the first clock after async_rst_n rises, ram_rd_reg_rst SHALL stay 1 and req_ready SHALL stay 0; from the second clock, ram_rd_reg_rst=0 and req_ready=1.
REQ-039 On reset assertion mid-operation, in-flight reads and queued responses SHALL be discarded with no response emitted.

Verification
REQ-040 RD_LATENCY=2: write 0xA5 to addr 3, then read addr 3 next cycle -> rsp_valid=1 with rsp_data=0xA5 exactly 3 cycles after the read issue.
REQ-041 RSP_DEPTH=4, rsp_ready=0: issue reads to addr 0..5 continuously -> exactly 4 issued, req_ready=0 thereafter, rsp_data=data[0] held stable.
REQ-042 From the full state of REQ-041, raise rsp_ready for 1 cycle -> one pop (data[0]), and req_ready=1 on the following cycle.
REQ-043 RD_LATENCY=1: 8 back-to-back reads with rsp_ready=1 -> 8 responses in order, first at issue+2, one per cycle, FIFO pointers wrapped.
REQ-044 Issue 3 reads, then pull async_rst_n low 1 cycle after the last issue -> rsp_valid=0 immediately, no responses after release, ram_rd_reg_rst=1 for 1 clock post-release.
REQ-045 Random valid/ready traffic, 10k cycles, against a reference memory model -> all read data matches, FIFO never overflows, and no response is issued for a write.
